// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN0,
        LEN1,
        WORD,
        WRITE,
        CSUM,
        VERIFY,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_CSUM     = 2'd2;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory port seen by the loader.
// mem_data is a shared bus: the loader drives it only while mem_we=1.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    wire  [DATA_WIDTH-1:0] mem_data;

    // Loader side: consumes bytes, owns the memory address/control.
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_addr,
        output mem_we,
        inout  mem_data
    );

    // Byte source and memory side.
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_addr,
        input  mem_we,
        inout  mem_data
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler. word is the shift register with the
// incoming byte already folded in, so the caller can capture a complete word
// (or the upper half, for the 16-bit count) on the accepting cycle itself.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [31:0] shift_q;
    logic [1:0]  cnt;

    assign word       = {byte_in, shift_q[31:8]};
    assign word_valid = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));

    // Byte position within the current word; clear restarts alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else if (byte_valid) begin
            cnt <= cnt + 2'd1;
        end
    end

    // Data shift register, newest byte enters at the top.
    always_ff @(posedge clk) begin
        if (byte_valid) begin
            shift_q <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed program, writes it into the
// instruction memory, then reads it back and checks the XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic [1:0]    error
);
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t                state, state_n;
    logic                  accept;
    logic                  pk_clear;
    logic [31:0]           pk_word;
    logic                  pk_valid;
    logic [15:0]           len_in;
    logic [15:0]           count;
    logic [15:0]           wcnt;
    logic [16:0]           vcnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we_q;
    logic                  last_word;
    logic                  verify_end;
    logic                  sample;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] csum;
    logic [DATA_WIDTH-1:0] acc;

    assign accept     = bus.rx_valid && bus.rx_ready;
    assign pk_clear   = (start && !busy) || (state == LEN1 && accept);
    assign len_in     = pk_word[31:16];
    assign last_word  = ({1'b0, wcnt} + 17'd1) == {1'b0, count};
    // VERIFY runs count+1 address cycles; the extra step is the compare.
    assign verify_end = vcnt == ({1'b0, count} + 17'd1);
    assign sample     = (state == VERIFY) && (vcnt != 17'd0) && (vcnt <= {1'b0, count});

    assign bus.rx_ready = (state == LEN0) || (state == LEN1) || (state == WORD) || (state == CSUM);
    assign busy         = !((state == IDLE) || (state == DONE) || (state == ERR));
    assign bus.mem_addr = addr;
    assign bus.mem_we   = we_q;
    // Bus enable shares the mem_we flop so both switch on the same edge.
    assign bus.mem_data = we_q ? wdata : 'z;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_in    (bus.rx_data),
        .byte_valid (accept),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_n = LEN0;
            LEN0:   if (accept) state_n = LEN1;
            LEN1: begin
                if (accept) begin
                    if ({1'b0, len_in} > CAPACITY) state_n = ERR;
                    else if (len_in == 16'd0)      state_n = CSUM;
                    else                           state_n = WORD;
                end
            end
            WORD:   if (pk_valid) state_n = WRITE;
            WRITE:  state_n = last_word ? CSUM : WORD;
            CSUM: begin
                if (pk_valid) begin
                    if (count != 16'd0)       state_n = VERIFY;
                    else if (pk_word == '0)   state_n = DONE;
                    else                      state_n = ERR;
                end
            end
            VERIFY: if (verify_end) state_n = (acc == csum) ? DONE : ERR;
            default: state_n = IDLE;
        endcase
    end

    // Control state: FSM, counters, address, write strobe and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            we_q  <= 1'b0;
            addr  <= '0;
            wcnt  <= 16'd0;
            vcnt  <= 17'd0;
            count <= 16'd0;
            done  <= 1'b0;
            error <= ERR_NONE;
        end else begin
            state <= state_n;
            we_q  <= (state_n == WRITE);
            if (state_n == DONE && state != DONE) done <= 1'b1;
            if (state_n == ERR && state != ERR) error <= (state == LEN1) ? ERR_OVERFLOW : ERR_CSUM;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done  <= 1'b0;
                        error <= ERR_NONE;
                        addr  <= '0;
                        wcnt  <= 16'd0;
                    end
                end
                LEN1:   if (accept) count <= len_in;
                WRITE: begin
                    addr <= addr + 1'b1;
                    wcnt <= wcnt + 16'd1;
                end
                CSUM: begin
                    addr <= '0;
                    vcnt <= 17'd0;
                end
                VERIFY: begin
                    addr <= addr + 1'b1;
                    vcnt <= vcnt + 17'd1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers: write word, received checksum, read-back XOR.
    always_ff @(posedge clk) begin
        if (state == WORD && pk_valid) wdata <= pk_word;
        if (state == CSUM && pk_valid) csum <= pk_word;
        if (state == CSUM)  acc <= '0;
        else if (sample)    acc <= acc ^ bus.mem_data;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed byte streams, registered-read memory
// model on the shared bus, and a queue-based scoreboard for writes and status.
module tb_imem_loader;
    import imem_loader_pkg::*;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic       done;
        logic [1:0] err;
        int         vwin;
    } st_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] error;

    int checks = 0;
    int errors = 0;

    wr_t wr_q[$];
    st_t st_q[$];

    logic [31:0] prog [0:2];
    logic [31:0] mem [0:1023];
    logic [31:0] mem_q = 32'h0;
    logic        mem_oe = 1'b0;
    logic [31:0] hold_val;
    logic        prev_busy = 1'b0;
    int          vwin = 0;

    imem_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifc ();

    imem_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (ifc),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, data returned the cycle after the address.
    always @(posedge clk) begin
        if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_data;
        mem_q  <= mem[ifc.mem_addr];
        mem_oe <= busy && !ifc.mem_we && !ifc.rx_ready;
    end

    // Memory side of the bus: read data when returning it, otherwise zero.
    assign hold_val     = mem_oe ? mem_q : 32'h0;
    assign ifc.mem_data = ifc.mem_we ? 32'hzzzz_zzzz : hold_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: writes, bus ownership, verify window length, end-of-load status.
    always @(negedge clk) begin
        if (ifc.mem_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("write_addr", 32'(ifc.mem_addr), 32'(w.addr));
                chk("write_data", ifc.mem_data, w.data);
            end
        end else begin
            chk("bus_released", ifc.mem_data, hold_val);
        end

        if (busy && !prev_busy) vwin = 0;
        if (busy && !ifc.mem_we && !ifc.rx_ready) vwin++;

        if (prev_busy && !busy) begin
            if (st_q.size() == 0) begin
                chk("unexpected_end", 32'd1, 32'd0);
            end else begin
                st_t s;
                s = st_q.pop_front();
                chk("done", 32'(done), 32'(s.done));
                chk("error", 32'(error), 32'(s.err));
                chk("verify_cycles", 32'(vwin), 32'(s.vwin));
                chk("rx_ready_end", 32'(ifc.rx_ready), 32'd0);
            end
        end
        prev_busy <= busy;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int  guard;
        logic rdy;
        if (stall) begin
            ifc.rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        guard = 0;
        forever begin
            rdy = ifc.rx_ready;
            @(negedge clk);
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                chk("byte_accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        ifc.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], stall);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    // Full stream: count, n words of prog[], checksum.
    task automatic load(input int n, input logic [31:0] cs, input bit stall,
                        input logic exp_done, input logic [1:0] exp_err, input int exp_vwin);
        logic [15:0] cnt;
        cnt = 16'(n);
        st_q.push_back('{exp_done, exp_err, exp_vwin});
        for (int i = 0; i < n; i++) wr_q.push_back('{10'(i), prog[i]});
        pulse_start();
        send_byte(cnt[7:0], stall);
        send_byte(cnt[15:8], stall);
        for (int i = 0; i < n; i++) send_word(prog[i], stall);
        send_word(cs, stall);
        wait_idle();
    endtask

    task automatic check_mem();
        chk("mem0", mem[0], 32'h2008_0005);
        chk("mem1", mem[1], 32'h2129_0001);
        chk("mem2", mem[2], 32'h0000_0000);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'h00;
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2129_0001;
        prog[2] = 32'h0000_0000;

        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(ifc.rx_ready), 32'd0);
        chk("rst_mem_addr", 32'(ifc.mem_addr), 32'd0);
        chk("rst_mem_we", 32'(ifc.mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic load: 3 words, correct checksum; verify window 3+1 plus compare.
        load(3, 32'h0121_0004, 1'b0, 1'b1, ERR_NONE, 5);
        check_mem();

        // Same program, wrong checksum.
        mem[0] = 32'h0; mem[1] = 32'h1; mem[2] = 32'h2;
        load(3, 32'h0121_0005, 1'b0, 1'b0, ERR_CSUM, 5);
        check_mem();

        // Overflow: count 1025.
        st_q.push_back('{1'b0, ERR_OVERFLOW, 0});
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        wait_idle();
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk("ovf_rx_ready", 32'(ifc.rx_ready), 32'd0);
        chk("ovf_error_held", 32'(error), 32'(ERR_OVERFLOW));
        ifc.rx_valid = 1'b0;

        // Empty program, good then bad checksum.
        load(0, 32'h0000_0000, 1'b0, 1'b1, ERR_NONE, 0);
        load(0, 32'h0000_0001, 1'b0, 1'b0, ERR_CSUM, 0);

        // Basic load with random rx_valid gaps.
        mem[0] = 32'h0; mem[1] = 32'h1; mem[2] = 32'h2;
        load(3, 32'h0121_0004, 1'b1, 1'b1, ERR_NONE, 5);
        check_mem();

        // Reset while assembling word 1.
        st_q.push_back('{1'b0, ERR_NONE, 0});
        wr_q.push_back('{10'd0, prog[0]});
        pulse_start();
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(prog[0], 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mem_we", 32'(ifc.mem_we), 32'd0);
        chk("mid_rst_bus", ifc.mem_data, hold_val);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rx_ready", 32'(ifc.rx_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        load(3, 32'h0121_0004, 1'b0, 1'b1, ERR_NONE, 5);
        check_mem();

        chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
        chk("status_queue_drained", 32'(st_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that fills the instruction memory from a byte stream before the processor runs. It accepts a length-prefixed program over a valid/ready byte interface and assembles little-endian 32-bit words. It writes the words into the instruction memory over that memory's shared bidirectional data bus, then reads every word back and checks it against a transmitted XOR checksum. It is the writer/verifier on the other end of the instruction memory port; the fetch path takes the memory only after `done`.

## Interface
- `ADDR_WIDTH`, 10: instruction memory address width; capacity is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width; fixed at 32, since assembly is 4 bytes per word.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte; a transfer happens when `rx_valid & rx_ready`.
- `mem_addr` out ADDR_WIDTH: instruction memory address.
- `mem_we` out 1: instruction memory write enable.
- `mem_data` inout DATA_WIDTH: shared data bus. Driven by the loader only while `mem_we=1`, otherwise high-Z.
- `busy` out 1: high in every state except IDLE, DONE and ERR.
- `done` out 1: sticky; load and verify passed.
- `error` out 2: sticky code. 0 = none, 1 = overflow (count > 2^ADDR_WIDTH), 2 = checksum mismatch.

## Operation
- **Stream format:** count[7:0], count[15:8], then count words of 4 bytes each (LSB first), then a 4-byte checksum (LSB first). The checksum is the XOR of all words.
- **FSM states:**
  - IDLE → LEN0 on `start`.
  - LEN0 → LEN1 on byte accept.
  - LEN1: on byte accept, go to ERR (error=1) if count > 2^ADDR_WIDTH; else go to CSUM if count = 0; else go to WORD.
  - WORD → WRITE after the 4th byte.
  - WRITE (exactly one cycle, `mem_we=1`, bus driven) → WORD, or → CSUM after the last word.
  - CSUM → VERIFY after the 4th byte.
  - VERIFY → DONE if the read-back XOR equals the received checksum, else ERR (error=2).
  - DONE/ERR → LEN0 on `start`; `start` clears `done` and `error`.
- `rx_ready` = 1 only in LEN0, LEN1, WORD and CSUM.
- The write address starts at 0 and increments after each WRITE.
- VERIFY reads addresses 0..count-1 with `mem_we=0` and the bus released. It XORs the returned words into a 32-bit accumulator.
- When count = 0, VERIFY is skipped; the received checksum must be 0 to reach DONE.
- `start` while busy is ignored.
- Address arithmetic is ADDR_WIDTH-bit. count = 2^ADDR_WIDTH is legal: the address wraps to 0 after the final write, and a separate 16-bit word counter terminates the load.

## Timing
- **Reset values:** IDLE, `rx_ready=0`, `mem_addr=0`, `mem_we=0`, bus high-Z, `busy=0`, `done=0`, `error=0`.
- **Reset mid-operation:** immediate return to IDLE with the bus released. Memory contents are then undefined, and `done` is not set.
- **Write cost:** one WRITE cycle per word. `rx_ready` is low during WRITE, so each word costs at least 5 cycles.
- **Read latency:** the memory registers its read data. An address presented in cycle t is valid on `mem_data` during cycle t+1.
- **VERIFY pipeline:**
  - Present address i in cycle i.
  - Sample the data for address i-1 in cycle i.
  - VERIFY therefore lasts count+1 cycles, then one compare cycle into DONE or ERR.
- **Bus turnaround:**
  - `mem_we` and the bus enable switch together on the same registered edge.
  - At least one cycle with `mem_we=0` separates the last WRITE from the first verify sample; no cycle has both ends driving the bus.
- `done` and `error` are registered. They assert the cycle after the decision and hold until `rst` or the next accepted `start`.

## Structure
- **Package `imem_loader_pkg`:**
  - FSM state enum: IDLE, LEN0, LEN1, WORD, WRITE, CSUM, VERIFY, DONE, ERR.
  - Error code constants: ERR_NONE, ERR_OVERFLOW, ERR_CSUM.
  - `BYTES_PER_WORD` = 4.
- **Sub-module `byte_packer`:** shift register plus 2-bit byte counter. It emits a 32-bit little-endian word and a one-cycle `word_valid`, and is reused for both the count and checksum fields.
- The top level holds the FSM, address/word counters, XOR accumulator and tri-state driver.

## Test plan
- **Basic load:** bytes 03 00, 05 00 08 20, 01 00 29 21, 00 00 00 00, 04 00 21 01 → memory[0..2] = 0x20080005, 0x21290001, 0x00000000; `done=1`, `error=0`.
- **Wrong checksum:** same stream with checksum 0x01210005 → memory written as above, `error=2`, `done=0`.
- **Overflow:** count bytes 01 04 (1025) with ADDR_WIDTH=10 → `error=1` after the second byte, `rx_ready=0`, no `mem_we` pulse.
- **Empty program:** count 0 then checksum 00 00 00 00 → `done=1`, zero write cycles; checksum 01 00 00 00 → `error=2`.
- **Stalls:** basic load with `rx_valid` toggled randomly → identical result. The bench checks the bus is never driven by the loader while `mem_we=0`, and that the verify phase lasts count+1 cycles.
- **Reset mid-load:** `rst` asserted during WORD of word 1 → next cycle IDLE, `mem_we=0`, bus high-Z, `done=0`. A following `start` plus the basic stream reaches `done=1`.
